// File: rtl/layer_mix_seq.sv
// layer_mix_seq: final video stage. Splits each pixel into a READ phase (sprite
// line-buffer fetch) and an ERASE phase (write-back of the transparent code), then
// resolves text / sprite / background priority into a palette address.
module layer_mix_seq #(
  parameter logic [7:0] ERASE_VAL = 8'hFF,
  parameter logic [8:0] HSTART    = 9'd0,
  parameter logic [3:0] CTRL_RST  = 4'hF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  input  logic        hblank,
  input  logic        vblank,
  input  logic [7:0]  spr_px,
  input  logic        spr_bank,
  input  logic [7:0]  bg_px,
  input  logic [1:0]  bg_bank,
  input  logic [7:0]  tx_px,
  input  logic        cpu_cs,
  input  logic        cpu_we,
  input  logic [3:0]  cpu_din,
  output logic        phase,
  output logic [8:0]  lb_addr,
  output logic        lb_we,
  output logic [7:0]  lb_wdata,
  output logic        pix_valid,
  output logic [10:0] pal_addr,
  output logic [2:0]  col_bank,
  output logic [1:0]  layer_sel
);

  localparam logic PH_READ  = 1'b0;
  localparam logic PH_ERASE = 1'b1;

  // phase FSM
  logic phase_q, phase_d;
  logic read_ce_s, erase_ce_s, lb_we_s;

  // line-buffer address / erase bookkeeping
  logic       hblank_q;
  logic       hb_rise_s;
  logic [8:0] lb_addr_q, lb_addr_d;
  logic       erase_pend_q, erase_pend_d;

  // control registers: shadow is CPU-visible, ctrl is the line-stable copy
  logic [3:0] ctrl_q, ctrl_d;
  logic [3:0] shadow_q, shadow_d;

  // stage-1 pixel capture
  logic [7:0] s1_spr_q, s1_bg_q, s1_tx_q;
  logic       s1_sbank_q;
  logic [1:0] s1_bbank_q;
  logic       s1_blank_q;

  // mixer result and output registers
  logic       mix_valid_s;
  logic [1:0] mix_layer_s;
  logic [2:0] mix_bank_s;
  logic [7:0] mix_index_s;
  logic       tx_opaque_s, spr_opaque_s, bg_shown_s;
  logic       pix_valid_q;
  logic [1:0] layer_q;
  logic [2:0] col_bank_q;
  logic [7:0] index_q;

  // Phase state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) phase_q <= PH_READ;
    else       phase_q <= phase_d;
  end

  // Phase next-state: toggle READ<->ERASE on every ce, hold otherwise
  always_comb begin
    phase_d = phase_q;
    case (phase_q)
      PH_READ:  if (ce) phase_d = PH_ERASE; else phase_d = PH_READ;
      PH_ERASE: if (ce) phase_d = PH_READ;  else phase_d = PH_ERASE;
      default:  phase_d = PH_READ;
    endcase
  end

  // Phase outputs: per-phase strobes; erase write is purely register-driven
  always_comb begin
    read_ce_s  = 1'b0;
    erase_ce_s = 1'b0;
    lb_we_s    = 1'b0;
    case (phase_q)
      PH_READ:  read_ce_s = ce;
      PH_ERASE: begin
        erase_ce_s = ce;
        lb_we_s    = erase_pend_q;
      end
      default: begin
        read_ce_s  = 1'b0;
        erase_ce_s = 1'b0;
        lb_we_s    = 1'b0;
      end
    endcase
  end

  // hblank rising edge is detected at clk rate, independent of ce
  assign hb_rise_s = hblank & ~hblank_q;

  // Address next-state: hblank reload beats the per-pixel increment
  always_comb begin
    lb_addr_d = lb_addr_q;
    if (hb_rise_s) begin
      lb_addr_d = HSTART;
    end else if (erase_ce_s && !hblank) begin
      lb_addr_d = lb_addr_q + 9'd1;
    end else begin
      lb_addr_d = lb_addr_q;
    end
  end

  // Erase-pending next-state: armed at READ outside hblank, cleared at ERASE
  always_comb begin
    erase_pend_d = erase_pend_q;
    if (read_ce_s) begin
      erase_pend_d = ~hblank;
    end else if (erase_ce_s) begin
      erase_pend_d = 1'b0;
    end else begin
      erase_pend_d = erase_pend_q;
    end
  end

  // Control next-state: CPU writes land in shadow; ctrl only follows at line start
  always_comb begin
    shadow_d = shadow_q;
    ctrl_d   = ctrl_q;
    if (cpu_cs && cpu_we) shadow_d = cpu_din;
    else                  shadow_d = shadow_q;
    if (hb_rise_s) ctrl_d = shadow_q;
    else           ctrl_d = ctrl_q;
  end

  // Sequencer and control state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hblank_q     <= 1'b0;
      lb_addr_q    <= HSTART;
      erase_pend_q <= 1'b0;
      ctrl_q       <= CTRL_RST;
      shadow_q     <= CTRL_RST;
    end else begin
      hblank_q     <= hblank;
      lb_addr_q    <= lb_addr_d;
      erase_pend_q <= erase_pend_d;
      ctrl_q       <= ctrl_d;
      shadow_q     <= shadow_d;
    end
  end

  // Stage-1 capture of all layer inputs at the READ ce
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_spr_q   <= 8'h00;
      s1_sbank_q <= 1'b0;
      s1_bg_q    <= 8'h00;
      s1_bbank_q <= 2'b00;
      s1_tx_q    <= 8'h00;
      s1_blank_q <= 1'b1;
    end else if (read_ce_s) begin
      s1_spr_q   <= spr_px;
      s1_sbank_q <= spr_bank;
      s1_bg_q    <= bg_px;
      s1_bbank_q <= bg_bank;
      s1_tx_q    <= tx_px;
      s1_blank_q <= hblank | vblank;
    end
  end

  assign tx_opaque_s  = (s1_tx_q[3:0] != 4'hF);
  assign spr_opaque_s = (s1_spr_q[2:1] != 2'b11);
  // background actually competes with the sprite only if enabled and opaque
  assign bg_shown_s   = ctrl_q[3] & (s1_bg_q[3:0] != 4'hF);

  // Priority mixer: blank, then text, then sprite, else background
  always_comb begin
    mix_valid_s = 1'b0;
    mix_layer_s = 2'b00;
    mix_bank_s  = 3'b000;
    mix_index_s = 8'h00;
    if (s1_blank_q) begin
      mix_valid_s = 1'b0;
    end else if (ctrl_q[1] && tx_opaque_s) begin
      mix_valid_s = 1'b1;
      mix_layer_s = 2'b10;
      mix_bank_s  = 3'b111;
      mix_index_s = s1_tx_q;
    end else if (ctrl_q[2] && spr_opaque_s && (ctrl_q[0] || !bg_shown_s)) begin
      mix_valid_s = 1'b1;
      mix_layer_s = 2'b01;
      mix_bank_s  = {2'b10, s1_sbank_q};
      mix_index_s = s1_spr_q;
    end else begin
      mix_valid_s = 1'b1;
      mix_layer_s = 2'b00;
      mix_bank_s  = {1'b0, s1_bbank_q};
      mix_index_s = ctrl_q[3] ? s1_bg_q : 8'hFF;
    end
  end

  // Mixer output registers, updated at the ERASE ce and held through READ
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_valid_q <= 1'b0;
      layer_q     <= 2'b00;
      col_bank_q  <= 3'b000;
      index_q     <= 8'h00;
    end else if (erase_ce_s) begin
      pix_valid_q <= mix_valid_s;
      layer_q     <= mix_layer_s;
      col_bank_q  <= mix_bank_s;
      index_q     <= mix_index_s;
    end
  end

  assign phase     = phase_q;
  assign lb_addr   = lb_addr_q;
  assign lb_we     = lb_we_s;
  assign lb_wdata  = ERASE_VAL;
  assign pix_valid = pix_valid_q;
  assign pal_addr  = {col_bank_q, index_q};
  assign col_bank  = col_bank_q;
  assign layer_sel = layer_q;

endmodule

// File: tb/tb_layer_mix_seq.sv
// Testbench for layer_mix_seq: directed scenarios plus randomized lines, all
// checked cycle by cycle against a pixel-level reference model.
module tb_layer_mix_seq;

  logic        clk = 1'b0;
  logic        reset, ce, hblank, vblank;
  logic [7:0]  spr_px, bg_px, tx_px;
  logic        spr_bank;
  logic [1:0]  bg_bank;
  logic        cpu_cs, cpu_we;
  logic [3:0]  cpu_din;
  logic        phase, lb_we, pix_valid;
  logic [8:0]  lb_addr;
  logic [7:0]  lb_wdata;
  logic [10:0] pal_addr;
  logic [2:0]  col_bank;
  logic [1:0]  layer_sel;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  logic       m_phase, m_pend, m_prev_hb, m_valid;
  logic [8:0] m_addr;
  logic [3:0] m_ctrl, m_shadow;
  logic [1:0] m_layer;
  logic [10:0] m_pal;
  // pixel captured at the last READ ce
  logic [7:0] c_tx, c_spr, c_bg;
  logic       c_sb, c_blank;
  logic [1:0] c_bb;

  layer_mix_seq dut (
    .clk(clk), .reset(reset), .ce(ce), .hblank(hblank), .vblank(vblank),
    .spr_px(spr_px), .spr_bank(spr_bank), .bg_px(bg_px), .bg_bank(bg_bank),
    .tx_px(tx_px), .cpu_cs(cpu_cs), .cpu_we(cpu_we), .cpu_din(cpu_din),
    .phase(phase), .lb_addr(lb_addr), .lb_we(lb_we), .lb_wdata(lb_wdata),
    .pix_valid(pix_valid), .pal_addr(pal_addr), .col_bank(col_bank),
    .layer_sel(layer_sel)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Priority rules written directly from the layer descriptions.
  // Returns {valid, layer[1:0], pal[10:0]}.
  function automatic logic [13:0] mix_ref(input logic [3:0] ctl, input logic blank,
                                          input logic [7:0] tx, input logic [7:0] spr,
                                          input logic sb, input logic [7:0] bg,
                                          input logic [1:0] bb);
    logic text_on, spr_on, bg_visible;
    text_on    = ctl[1] && (tx[3:0] != 4'hF);
    spr_on     = ctl[2] && (spr[2:1] != 2'b11);
    bg_visible = ctl[3] && (bg[3:0] != 4'hF);
    if (blank)                            return 14'd0;
    if (text_on)                          return {1'b1, 2'b10, 3'b111, tx};
    if (spr_on && (ctl[0] || !bg_visible)) return {1'b1, 2'b01, 2'b10, sb, spr};
    return {1'b1, 2'b00, 1'b0, bb, (ctl[3] ? bg : 8'hFF)};
  endfunction

  task automatic model_reset();
    m_phase = 1'b0; m_pend = 1'b0; m_prev_hb = 1'b0; m_valid = 1'b0;
    m_addr = 9'd0; m_ctrl = 4'hF; m_shadow = 4'hF; m_layer = 2'b00; m_pal = 11'd0;
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_edge();
    logic hb_rise;
    logic [13:0] r;
    hb_rise = hblank && !m_prev_hb;
    if (ce) begin
      if (!m_phase) begin
        c_tx = tx_px; c_spr = spr_px; c_sb = spr_bank; c_bg = bg_px; c_bb = bg_bank;
        c_blank = hblank | vblank;
        m_pend = !hblank;
      end else begin
        m_pend = 1'b0;
        r = mix_ref(m_ctrl, c_blank, c_tx, c_spr, c_sb, c_bg, c_bb);
        m_valid = r[13]; m_layer = r[12:11]; m_pal = r[10:0];
        if (!hblank) m_addr = m_addr + 9'd1;
      end
      m_phase = !m_phase;
    end
    if (hb_rise) begin
      m_addr = 9'd0;
      m_ctrl = m_shadow;
    end
    if (cpu_cs && cpu_we) m_shadow = cpu_din;
    m_prev_hb = hblank;
  endtask

  task automatic compare_all();
    check_val("phase",     phase,     m_phase);
    check_val("lb_addr",   lb_addr,   m_addr);
    check_val("lb_we",     lb_we,     m_phase & m_pend);
    check_val("lb_wdata",  lb_wdata,  8'hFF);
    check_val("pix_valid", pix_valid, m_valid);
    check_val("pal_addr",  pal_addr,  m_pal);
    check_val("col_bank",  col_bank,  m_pal[10:8]);
    check_val("layer_sel", layer_sel, m_layer);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic set_px(input logic [7:0] tx, input logic [7:0] spr, input logic sb,
                        input logic [7:0] bg, input logic [1:0] bb);
    tx_px = tx; spr_px = spr; spr_bank = sb; bg_px = bg; bg_bank = bb;
  endtask

  task automatic hblank_pulse();
    hblank = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    hblank = 1'b0;
  endtask

  task automatic rand_inputs();
    logic [7:0] v;
    ce = ($urandom_range(3, 0) != 0);
    v = 8'($urandom); if ($urandom_range(1, 0) == 1) v[3:0] = 4'hF; tx_px = v;
    v = 8'($urandom); if ($urandom_range(1, 0) == 1) v[2:1] = 2'b11; spr_px = v;
    v = 8'($urandom); if ($urandom_range(2, 0) == 0) v[3:0] = 4'hF; bg_px = v;
    spr_bank = 1'($urandom);
    bg_bank  = 2'($urandom);
    cpu_cs   = ($urandom_range(24, 0) == 0);
    cpu_we   = cpu_cs;
    cpu_din  = 4'($urandom);
  endtask

  initial begin
    int guard;
    reset = 1'b1; ce = 1'b0; hblank = 1'b0; vblank = 1'b0;
    cpu_cs = 1'b0; cpu_we = 1'b0; cpu_din = 4'h0;
    set_px(8'h00, 8'h00, 1'b0, 8'h00, 2'b00);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    compare_all();

    // text wins with all layers enabled
    ce = 1'b1;
    set_px(8'h12, 8'h30, 1'b0, 8'h45, 2'b00);
    cycle();
    check_val("read_to_erase", phase, 1'b1);
    check_val("we_in_erase",   lb_we, 1'b1);
    cycle();
    check_val("text_pal",   pal_addr,  11'h712);
    check_val("text_layer", layer_sel, 2'b10);
    check_val("addr_step1", lb_addr,   9'd1);

    // sprite over opaque background
    set_px(8'hFF, 8'h30, 1'b1, 8'h45, 2'b10);
    cycle(); cycle();
    check_val("spr_pal",   pal_addr,  11'h530);
    check_val("spr_layer", layer_sel, 2'b01);

    // ctrl=E written mid-line: not visible until next line
    cpu_cs = 1'b1; cpu_we = 1'b1; cpu_din = 4'hE;
    cycle();
    cpu_cs = 1'b0; cpu_we = 1'b0;
    cycle();
    check_val("midline_hold", pal_addr, 11'h530);
    hblank_pulse();
    cycle(); cycle();
    check_val("bg_pal",   pal_addr,  11'h245);
    check_val("bg_layer", layer_sel, 2'b00);

    // ctrl=0 written mid-line, then committed: background with index FF
    cpu_cs = 1'b1; cpu_we = 1'b1; cpu_din = 4'h0;
    cycle();
    cpu_cs = 1'b0; cpu_we = 1'b0;
    cycle();
    check_val("midline_hold2", pal_addr, 11'h245);
    hblank_pulse();
    cycle(); cycle();
    check_val("off_pal",   pal_addr,  11'h2FF);
    check_val("off_layer", layer_sel, 2'b00);

    // run to address 300 then raise hblank
    guard = 0;
    while (!(m_addr == 9'd300 && !m_phase) && guard < 2000) begin
      cycle();
      guard++;
    end
    check_val("addr_300", lb_addr, 9'd300);
    hblank = 1'b1;
    cycle();
    check_val("hb_reload", lb_addr, 9'd0);
    check_val("hb_no_we",  lb_we,   1'b0);
    cycle();
    check_val("hb_blank", pix_valid, 1'b0);
    cycle(); cycle();
    hblank = 1'b0;

    // async reset in the middle of an ERASE phase
    cycle();
    check_val("we_pre_rst", lb_we, 1'b1);
    #2 reset = 1'b1;
    #1;
    check_val("rst_we",    lb_we,     1'b0);
    check_val("rst_phase", phase,     1'b0);
    check_val("rst_valid", pix_valid, 1'b0);
    check_val("rst_pal",   pal_addr,  11'd0);
    check_val("rst_addr",  lb_addr,   9'd0);
    check_val("rst_layer", layer_sel, 2'b00);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    compare_all();

    // randomized lines
    for (int ln = 0; ln < 12; ln++) begin
      int act_len, hb_len;
      act_len = $urandom_range(200, 20);
      hb_len  = $urandom_range(20, 4);
      vblank  = ($urandom_range(4, 0) == 0);
      hblank  = 1'b0;
      for (int i = 0; i < act_len; i++) begin
        rand_inputs();
        cycle();
      end
      hblank = 1'b1;
      for (int i = 0; i < hb_len; i++) begin
        rand_inputs();
        if (i == 0 && $urandom_range(1, 0) == 1) begin
          cpu_cs = 1'b1; cpu_we = 1'b1;
        end
        cycle();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
